// File: rtl/sum_alarm_monitor.sv
// sum_alarm_monitor: debounced, hysteretic alarm on an incoming running sum.
// It also tracks the peak sample and a saturating count of alarm episodes.
// Every output comes straight from a flop.
module sum_alarm_monitor #(
  parameter int W     = 5,
  parameter int HI    = 20,
  parameter int LO    = 10,
  parameter int N_ON  = 3,
  parameter int N_OFF = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [W-1:0]  d,
  output logic          alarm,
  output logic [W-1:0]  peak,
  output logic [CW-1:0] events
);

  localparam int ONW  = $clog2(N_ON + 1);
  localparam int OFFW = $clog2(N_OFF + 1);

  localparam logic [W-1:0]    HI_W     = W'(HI);
  localparam logic [W-1:0]    LO_W     = W'(LO);
  localparam logic [ONW-1:0]  ON_LAST  = ONW'(N_ON - 1);
  localparam logic [OFFW-1:0] OFF_LAST = OFFW'(N_OFF - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ALARM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          alarm_q, alarm_d;
  logic [ONW-1:0]  on_q,  on_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [W-1:0]  peak_q, peak_d;
  logic [CW-1:0] ev_q, ev_d;

  logic hi_s, lo_s;
  assign hi_s = d > HI_W;
  assign lo_s = d < LO_W;

  // Next-state: the FSM and the peak tracker advance only on sampled cycles; clr wins over peak/events.
  always_comb begin
    state_d = state_q;
    alarm_d = alarm_q;
    on_d    = on_q;
    off_d   = off_q;
    peak_d  = peak_q;
    ev_d    = ev_q;
    if (en) begin
      if (d > peak_q) peak_d = d;
      case (state_q)
        S_IDLE: begin
          if (hi_s) begin
            if (on_q == ON_LAST) begin
              state_d = S_ALARM;
              alarm_d = 1'b1;
              on_d    = '0;
              if (ev_q != {CW{1'b1}}) ev_d = ev_q + 1'b1;
            end else begin
              on_d = on_q + 1'b1;
            end
          end else begin
            on_d = '0;
          end
        end
        default: begin
          if (lo_s) begin
            if (off_q == OFF_LAST) begin
              state_d = S_IDLE;
              alarm_d = 1'b0;
              off_d   = '0;
            end else begin
              off_d = off_q + 1'b1;
            end
          end else begin
            off_d = '0;
          end
        end
      endcase
    end
    if (clr) begin
      peak_d = '0;
      ev_d   = '0;
    end
  end

  // State registers; rst drops a partial run immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      alarm_q <= 1'b0;
      on_q    <= '0;
      off_q   <= '0;
      peak_q  <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      alarm_q <= alarm_d;
      on_q    <= on_d;
      off_q   <= off_d;
      peak_q  <= peak_d;
      ev_q    <= ev_d;
    end
  end

  assign alarm  = alarm_q;
  assign peak   = peak_q;
  assign events = ev_q;

endmodule

// File: tb/tb_sum_alarm_monitor.sv
// Directed bench for sum_alarm_monitor: default instance plus a CW=2 instance
// driven by the same stimulus to exercise event-counter saturation.
module tb_sum_alarm_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] d   = '0;

  logic       alarm,  alarm2;
  logic [4:0] peak,   peak2;
  logic [7:0] events;
  logic [1:0] events2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_alarm_monitor dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
    .alarm(alarm), .peak(peak), .events(events)
  );

  sum_alarm_monitor #(.CW(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
    .alarm(alarm2), .peak(peak2), .events(events2)
  );

  // drive one sample at the falling edge, then sample outputs 1 after the rising edge
  task automatic samp(input logic [4:0] v, input logic e = 1'b1, input logic c = 1'b0);
    @(negedge clk);
    d = v; en = e; clr = c;
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; clr = 1'b0; d = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    checks++; if (peak !== 5'd0) begin failures++; $display("FAIL reset_peak got=%0d exp=0", peak); end
    checks++; if (events !== 8'd0) begin failures++; $display("FAIL reset_events got=%0d exp=0", events); end
    checks++; if (events2 !== 2'd0) begin failures++; $display("FAIL reset_events2 got=%0d exp=0", events2); end
    do_reset();
  endtask

  task automatic test_basic_on();
    logic [4:0] dv[3] = '{5'd21, 5'd25, 5'd30};
    logic       ea[3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      samp(dv[i]);
      checks++;
      if (alarm !== ea[i]) begin failures++; $display("FAIL basic_alarm[%0d] got=%b exp=%b", i, alarm, ea[i]); end
    end
    checks++; if (events !== 8'd1) begin failures++; $display("FAIL basic_events got=%0d exp=1", events); end
    checks++; if (peak !== 5'd30) begin failures++; $display("FAIL basic_peak got=%0d exp=30", peak); end
  endtask

  task automatic test_run_break();
    logic [4:0] dv[5] = '{5'd21, 5'd21, 5'd20, 5'd21, 5'd22};
    logic       ea[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      samp(dv[i]);
      checks++;
      if (alarm !== ea[i]) begin failures++; $display("FAIL break_alarm[%0d] got=%b exp=%b", i, alarm, ea[i]); end
    end
    samp(5'd23);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL break_alarm_final got=%b exp=1", alarm); end
    checks++; if (events !== 8'd1) begin failures++; $display("FAIL break_events got=%0d exp=1", events); end
  endtask

  task automatic test_gaps();
    do_reset();
    samp(5'd21);
    for (int i = 0; i < 5; i++) samp(5'd31, 1'b0);
    checks++; if (peak !== 5'd21) begin failures++; $display("FAIL gap_peak got=%0d exp=21", peak); end
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL gap_alarm_hold got=%b exp=0", alarm); end
    samp(5'd21);
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL gap_alarm2 got=%b exp=0", alarm); end
    samp(5'd21);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL gap_alarm3 got=%b exp=1", alarm); end
  endtask

  // continues from the ALARM state left by test_gaps
  task automatic test_off();
    logic [4:0] dv[4] = '{5'd9, 5'd10, 5'd9, 5'd5};
    logic       ea[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      samp(dv[i]);
      checks++;
      if (alarm !== ea[i]) begin failures++; $display("FAIL off_alarm[%0d] got=%b exp=%b", i, alarm, ea[i]); end
    end
    checks++; if (events !== 8'd1) begin failures++; $display("FAIL off_events got=%0d exp=1", events); end
    checks++; if (peak !== 5'd21) begin failures++; $display("FAIL off_peak got=%0d exp=21", peak); end
  endtask

  task automatic test_async_rst();
    do_reset();
    samp(5'd21); samp(5'd21); samp(5'd21);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL arst_pre_alarm got=%b exp=1", alarm); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL arst_alarm got=%b exp=0", alarm); end
    checks++; if (peak !== 5'd0) begin failures++; $display("FAIL arst_peak got=%0d exp=0", peak); end
    checks++; if (events !== 8'd0) begin failures++; $display("FAIL arst_events got=%0d exp=0", events); end
    @(negedge clk);
    rst = 1'b0;
    samp(5'd21); samp(5'd21);
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL arst_post_alarm got=%b exp=0", alarm); end
  endtask

  task automatic test_saturate_clr();
    logic [1:0] e2[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int ep = 0; ep < 4; ep++) begin
      samp(5'd21); samp(5'd21); samp(5'd21);
      checks++;
      if (events2 !== e2[ep]) begin failures++; $display("FAIL sat_events2[%0d] got=%0d exp=%0d", ep, events2, e2[ep]); end
      if (ep < 3) begin samp(5'd5); samp(5'd5); end
    end
    checks++; if (events !== 8'd4) begin failures++; $display("FAIL sat_events8 got=%0d exp=4", events); end
    samp(5'd31, 1'b1, 1'b1);
    checks++; if (peak2 !== 5'd0) begin failures++; $display("FAIL clr_peak got=%0d exp=0", peak2); end
    checks++; if (events2 !== 2'd0) begin failures++; $display("FAIL clr_events got=%0d exp=0", events2); end
    checks++; if (alarm2 !== 1'b1) begin failures++; $display("FAIL clr_alarm got=%b exp=1", alarm2); end
    samp(5'd12);
    checks++; if (peak !== 5'd12) begin failures++; $display("FAIL clr_peak_resume got=%0d exp=12", peak); end
  endtask

  // clr on the very edge that enters ALARM suppresses the increment but not the transition
  task automatic test_clr_override();
    do_reset();
    samp(5'd21); samp(5'd21);
    samp(5'd21, 1'b1, 1'b1);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL clrov_alarm got=%b exp=1", alarm); end
    checks++; if (events !== 8'd0) begin failures++; $display("FAIL clrov_events got=%0d exp=0", events); end
    checks++; if (peak !== 5'd0) begin failures++; $display("FAIL clrov_peak got=%0d exp=0", peak); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_basic_on();
        test_run_break();
        test_gaps();
        test_off();
        test_async_rst();
        test_saturate_clr();
        test_clr_override();
      end
      begin
        #50000;
        $display("FAIL timeout reached");
        failures++;
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
